csa_pipe_acc: RTL and testbench
===============================

CSA_PIPE_ACC -- requirements
Module: csa_pipe_acc

Interface
REQ-001 Parameter WIDTH, default 20, SHALL set the operand width (legal values 4..64).
REQ-002 Parameter ACC_W, default 24, SHALL set the accumulator and result width; elaboration SHALL fail if ACC_W < WIDTH+2.
REQ-003 clk  in  1  SHALL be the single clock; all state SHALL update on the rising edge.
REQ-004 rst_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 in_valid  in  1  SHALL mark that an operand triple is offered.
REQ-006 in_ready  out  1  SHALL indicate that the block can accept a triple this cycle.
REQ-007 in_a, in_b, in_c  in  WIDTH each  SHALL be unsigned operands.
REQ-008 in_mode  in  2  SHALL select the mode: 0 = sum, 1 = accumulate, 2 = load, 3 = reserved.
REQ-009 out_valid  out  1  SHALL mark a valid result.
REQ-010 out_ready  in  1  SHALL indicate that the consumer accepts the result.
REQ-011 out_sum, out_carry  out  ACC_W each  SHALL be the carry-save result; the carry bits SHALL be pre-weighted, so total = out_sum + out_carry mod 2^ACC_W.
REQ-012 out_total  out  ACC_W  SHALL be the carry-propagated total.

Function
REQ-013 A transfer SHALL occur on any cycle in which in_valid and in_ready are both high; the same rule SHALL apply to out_valid and out_ready.
REQ-014 The pipeline SHALL have three registered stages: S1 (3:2 compression of a, b, c), S2 (4:2 merge with the accumulator), S3 (carry-propagate add).
REQ-015 Latency SHALL be exactly 3 cycles from acceptance to out_valid when no stall occurs; throughput SHALL be 1 transaction per cycle.
REQ-016 stall = out_valid AND NOT out_ready; in_ready SHALL equal NOT stall; every stage SHALL hold while stall is high; bubbles SHALL NOT be collapsed.
REQ-017 Operands SHALL be zero-extended to ACC_W; all arithmetic SHALL wrap modulo 2^ACC_W with no overflow flag.
REQ-018 Mode 0 SHALL output a+b+c and SHALL leave the accumulator unchanged.
REQ-019 Mode 1 SHALL set the accumulator to accumulator + a + b + c and SHALL output the new accumulator value.
REQ-020 Mode 2 SHALL set the accumulator to a + b + c, discarding the previous value, and SHALL output that value.
REQ-021 Mode 3 SHALL behave exactly as mode 0.
REQ-022 The accumulator SHALL be held in carry-save form (acc_s, acc_c) and SHALL update only on a cycle in which S2 holds a valid transaction and stall is low.
REQ-023 Back-to-back mode-1 transactions SHALL see each predecessor's update with no hazard and no stall.
REQ-024 Results SHALL leave the block in acceptance order, and no transaction SHALL be lost or duplicated under any out_ready pattern.
REQ-025 out_sum, out_carry and out_total SHALL hold stable while out_valid is high and out_ready is low.

Reset
REQ-026 While rst_n is low: all stage valids, acc_s, acc_c, out_sum, out_carry and out_total SHALL be 0, out_valid SHALL be 0, and in_ready SHALL be 1.
REQ-027 Reset asserted mid-operation SHALL discard all in-flight transactions and the accumulator; operation SHALL resume on the first edge after release.

Structure
REQ-028 Package csa_pkg SHALL hold the mode enum (MODE_SUM, MODE_ACC, MODE_LOAD, MODE_RSVD) and the default WIDTH and ACC_W constants.
REQ-029 Combinational sub-module csa_row #(W) (a W-bit 3:2 compressor row producing sum and weighted carry) SHALL be instantiated 3 times: once in S1, twice in S2.
REQ-030 The S3 carry-propagate add SHALL be inferred and SHALL NOT be a sub-module.

Verification
REQ-031 Mode 0, a=b=c=0xFFFFF -> out_total=0x2FFFFD, out_sum+out_carry=0x2FFFFD, out_valid exactly 3 cycles after acceptance.
REQ-032 Mode 2 (1,2,3) followed on the next cycle by mode 1 (4,5,6) -> out_total 6 then 21 on consecutive cycles.
REQ-033 Mode 2 (0xFFFFF x3) then 5 mode-1 repeats of (0xFFFFF x3) -> final out_total=0x1FFFEE (wrap at 2^24).
REQ-034 out_ready low for 5 cycles while in_valid is held high with 4 triples -> exactly 3 accepted, in_ready low from the cycle out_valid rises; after release all 4 results emerge in order and stable.
REQ-035 Mode 2 (7,0,0), rst_n pulsed low mid-flight, then mode 1 (1,1,1) -> out_valid 0 during reset, next out_total=3.
REQ-036 Mode 2 (1,0,0), then mode 3 (5,5,5), then mode 1 (0,0,0) -> out_total 1, 15, 1.

Source files
------------

// File: rtl/csa_pkg.sv
// Shared definitions for the carry-save pipelined accumulator: mode encoding and default widths.
// Latency: none (definitions only).
// Backpressure: not applicable.
package csa_pkg;

    localparam int DEF_WIDTH = 20;
    localparam int DEF_ACC_W = 24;

    typedef enum logic [1:0] {
        MODE_SUM  = 2'd0,
        MODE_ACC  = 2'd1,
        MODE_LOAD = 2'd2,
        MODE_RSVD = 2'd3
    } mode_e;

endpackage

// File: rtl/csa_row.sv
// W-bit 3:2 compressor row: sum = a^b^c, carry = majority(a,b,c) pre-shifted by one (weighted).
// Latency: purely combinational.
// Backpressure: none; the caller owns any holding.
// Ports: a, b, c in (W); sum, carry out (W); sum + carry == a + b + c mod 2^W.
module csa_row #(
    parameter int W = 24
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] sum,
    output logic [W-1:0] carry
);

    assign sum   = a ^ b ^ c;
    // Shifting the full vector drops the top majority bit, which is the mod 2^W wrap.
    assign carry = ((a & b) | (a & c) | (b & c)) << 1;

endmodule

// File: rtl/csa_pipe_acc.sv
// Three-stage carry-save adder/accumulator: S1 3:2 of a,b,c; S2 4:2 merge with acc; S3 carry-propagate.
// Latency: 3 cycles acceptance-to-out_valid, 1 transaction/cycle.
// Backpressure: stall = out_valid & ~out_ready freezes every stage; in_ready = ~stall.
// Ports: clk, rst_n (async, active-low); in_valid/in_ready, in_a/in_b/in_c (WIDTH), in_mode (2);
//        out_valid/out_ready, out_sum/out_carry (ACC_W, carry-save), out_total (ACC_W).
module csa_pipe_acc
    import csa_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_c,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [ACC_W-1:0] out_carry,
    output logic [ACC_W-1:0] out_total
);

    // Three operands can grow by two bits; a narrower accumulator would lose a single sum.
    generate
        if (ACC_W < WIDTH + 2) begin : g_bad_acc_w
            $error("csa_pipe_acc: ACC_W must be at least WIDTH+2");
        end
        if (WIDTH < 4 || WIDTH > 64) begin : g_bad_width
            $error("csa_pipe_acc: WIDTH must be in 4..64");
        end
    endgenerate

    logic             stall;
    logic             adv;

    // S1 registers: compressed operand pair
    logic             s1_vld;
    mode_e            s1_mode;
    logic [ACC_W-1:0] s1_sum;
    logic [ACC_W-1:0] s1_carry;

    // S2 registers and the carry-save accumulator
    logic             s2_vld;
    logic [ACC_W-1:0] s2_sum;
    logic [ACC_W-1:0] s2_carry;
    logic [ACC_W-1:0] acc_s;
    logic [ACC_W-1:0] acc_c;

    logic             s3_vld;

    logic [ACC_W-1:0] a_ext;
    logic [ACC_W-1:0] b_ext;
    logic [ACC_W-1:0] c_ext;
    logic [ACC_W-1:0] r1_sum;
    logic [ACC_W-1:0] r1_carry;
    logic [ACC_W-1:0] m_in_s;
    logic [ACC_W-1:0] m_in_c;
    logic [ACC_W-1:0] m1_sum;
    logic [ACC_W-1:0] m1_carry;
    logic [ACC_W-1:0] m2_sum;
    logic [ACC_W-1:0] m2_carry;
    logic             acc_we;

    assign stall     = s3_vld & ~out_ready;
    assign adv       = ~stall;
    assign in_ready  = ~stall;
    assign out_valid = s3_vld;

    assign a_ext = {{(ACC_W-WIDTH){1'b0}}, in_a};
    assign b_ext = {{(ACC_W-WIDTH){1'b0}}, in_b};
    assign c_ext = {{(ACC_W-WIDTH){1'b0}}, in_c};

    csa_row #(.W(ACC_W)) u_row_s1 (
        .a     (a_ext),
        .b     (b_ext),
        .c     (c_ext),
        .sum   (r1_sum),
        .carry (r1_carry)
    );

    // Only accumulate mode folds in the old accumulator; every other mode merges with zero,
    // so sum/reserved/load all produce a+b+c through the same two rows.
    assign m_in_s = (s1_mode == MODE_ACC) ? acc_s : '0;
    assign m_in_c = (s1_mode == MODE_ACC) ? acc_c : '0;

    csa_row #(.W(ACC_W)) u_row_s2a (
        .a     (s1_sum),
        .b     (s1_carry),
        .c     (m_in_s),
        .sum   (m1_sum),
        .carry (m1_carry)
    );

    csa_row #(.W(ACC_W)) u_row_s2b (
        .a     (m1_sum),
        .b     (m1_carry),
        .c     (m_in_c),
        .sum   (m2_sum),
        .carry (m2_carry)
    );

    // The accumulator is written on the same edge that moves the transaction out of S2,
    // so the next transaction in S2 sees the update without forwarding or stalling.
    assign acc_we = adv & s1_vld & ((s1_mode == MODE_ACC) | (s1_mode == MODE_LOAD));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld    <= 1'b0;
            s1_mode   <= MODE_SUM;
            s1_sum    <= '0;
            s1_carry  <= '0;
            s2_vld    <= 1'b0;
            s2_sum    <= '0;
            s2_carry  <= '0;
            acc_s     <= '0;
            acc_c     <= '0;
            s3_vld    <= 1'b0;
            out_sum   <= '0;
            out_carry <= '0;
            out_total <= '0;
        end else begin
            if (adv) begin
                // Valids always advance so bubbles keep their slot.
                s1_vld <= in_valid;
                s2_vld <= s1_vld;
                s3_vld <= s2_vld;
                if (in_valid) begin
                    s1_mode  <= mode_e'(in_mode);
                    s1_sum   <= r1_sum;
                    s1_carry <= r1_carry;
                end
                if (s1_vld) begin
                    s2_sum   <= m2_sum;
                    s2_carry <= m2_carry;
                end
                if (s2_vld) begin
                    out_sum   <= s2_sum;
                    out_carry <= s2_carry;
                    out_total <= s2_sum + s2_carry;
                end
            end
            if (acc_we) begin
                acc_s <= m2_sum;
                acc_c <= m2_carry;
            end
        end
    end

endmodule

// File: tb/tb_csa_pipe_acc.sv
// Directed bench for csa_pipe_acc with default WIDTH=20, ACC_W=24.
// Each scenario task drives its stimulus and compares against hand-computed values.
// Results are collected by a monitor at the falling edge whenever out_valid & out_ready.
module tb_csa_pipe_acc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [19:0] in_a;
    logic [19:0] in_b;
    logic [19:0] in_c;
    logic [1:0]  in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_sum;
    logic [23:0] out_carry;
    logic [23:0] out_total;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct packed {
        logic [23:0] total;
        logic [23:0] sum;
        logic [23:0] carry;
        logic [31:0] cyc;
    } res_t;

    res_t res_q[$];
    res_t mon_r;

    csa_pipe_acc #(.WIDTH(20), .ACC_W(24)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_c      (in_c),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_carry (out_carry),
        .out_total (out_total)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            mon_r.total = out_total;
            mon_r.sum   = out_sum;
            mon_r.carry = out_carry;
            mon_r.cyc   = cyc;
            res_q.push_back(mon_r);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [1:0] m, input logic [19:0] a, input logic [19:0] b,
                        input logic [19:0] c, output int acc_cyc);
        bit done = 1'b0;
        int n = 0;
        in_valid = 1'b1;
        in_mode  = m;
        in_a     = a;
        in_b     = b;
        in_c     = c;
        acc_cyc  = -1;
        while (!done && n < 50) begin
            @(negedge clk);
            if (in_ready) begin
                done = 1'b1;
                acc_cyc = cyc;
            end
            @(posedge clk);
            #1;
            n++;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: in_ready never high, got %0b want 1", in_ready);
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_results(input int n);
        int k = 0;
        while (res_q.size() < n && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (res_q.size() < n) begin
            checks++;
            failures++;
            $display("FAIL result_timeout: got %0d results want %0d", res_q.size(), n);
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_mode   = 2'd0;
        in_a      = '0;
        in_b      = '0;
        in_c      = '0;
        out_ready = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL reset_out_valid: got %0b want 0", out_valid);
            end
            checks++;
            if (in_ready !== 1'b1) begin
                failures++;
                $display("FAIL reset_in_ready: got %0b want 1", in_ready);
            end
            checks++;
            if (out_total !== 24'h0 || out_sum !== 24'h0 || out_carry !== 24'h0) begin
                failures++;
                $display("FAIL reset_outputs: got total=%h sum=%h carry=%h want 0", out_total, out_sum, out_carry);
            end
            checks++;
            if (dut.acc_s !== 24'h0 || dut.acc_c !== 24'h0) begin
                failures++;
                $display("FAIL reset_acc: got acc_s=%h acc_c=%h want 0", dut.acc_s, dut.acc_c);
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);
    endtask

    task automatic test_sum_max();
        int ac;
        logic [23:0] cs;
        res_q.delete();
        send(2'd0, 20'hFFFFF, 20'hFFFFF, 20'hFFFFF, ac);
        idle(1);
        wait_results(1);
        if (res_q.size() >= 1) begin
            checks++;
            if (res_q[0].total !== 24'h2FFFFD) begin
                failures++;
                $display("FAIL sum_max_total: got %h want 2ffffd", res_q[0].total);
            end
            cs = res_q[0].sum + res_q[0].carry;
            checks++;
            if (cs !== 24'h2FFFFD) begin
                failures++;
                $display("FAIL sum_max_carry_save: got %h want 2ffffd", cs);
            end
            checks++;
            if (int'(res_q[0].cyc) - ac !== 3) begin
                failures++;
                $display("FAIL sum_max_latency: got %0d want 3", int'(res_q[0].cyc) - ac);
            end
        end
        idle(3);
    endtask

    task automatic test_back_to_back();
        int ac0, ac1;
        res_q.delete();
        send(2'd2, 20'd1, 20'd2, 20'd3, ac0);
        send(2'd1, 20'd4, 20'd5, 20'd6, ac1);
        idle(1);
        wait_results(2);
        if (res_q.size() >= 2) begin
            checks++;
            if (res_q[0].total !== 24'd6) begin
                failures++;
                $display("FAIL b2b_load_total: got %0d want 6", res_q[0].total);
            end
            checks++;
            if (res_q[1].total !== 24'd21) begin
                failures++;
                $display("FAIL b2b_acc_total: got %0d want 21", res_q[1].total);
            end
            checks++;
            if (res_q[1].cyc - res_q[0].cyc !== 32'd1) begin
                failures++;
                $display("FAIL b2b_consecutive: got gap %0d want 1", res_q[1].cyc - res_q[0].cyc);
            end
            checks++;
            if (ac1 - ac0 !== 1) begin
                failures++;
                $display("FAIL b2b_no_stall: got accept gap %0d want 1", ac1 - ac0);
            end
        end
        idle(3);
    endtask

    task automatic test_wrap();
        int ac;
        logic [23:0] exp_t [6];
        exp_t[0] = 24'h2FFFFD;
        exp_t[1] = 24'h5FFFFA;
        exp_t[2] = 24'h8FFFF7;
        exp_t[3] = 24'hBFFFF4;
        exp_t[4] = 24'hEFFFF1;
        exp_t[5] = 24'h1FFFEE;
        res_q.delete();
        send(2'd2, 20'hFFFFF, 20'hFFFFF, 20'hFFFFF, ac);
        for (int i = 0; i < 5; i++) send(2'd1, 20'hFFFFF, 20'hFFFFF, 20'hFFFFF, ac);
        idle(1);
        wait_results(6);
        if (res_q.size() >= 6) begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (res_q[i].total !== exp_t[i]) begin
                    failures++;
                    $display("FAIL wrap_total[%0d]: got %h want %h", i, res_q[i].total, exp_t[i]);
                end
            end
        end
        idle(3);
    endtask

    task automatic test_backpressure();
        logic [19:0] va [4];
        logic [23:0] exp_t [4];
        logic        exp_rdy [5];
        logic [23:0] cs;
        int  idx = 0;
        int  n = 0;
        bit  acc;
        va[0] = 20'd1;  exp_t[0] = 24'd3;
        va[1] = 20'd2;  exp_t[1] = 24'd6;
        va[2] = 20'd3;  exp_t[2] = 24'd9;
        va[3] = 20'd20; exp_t[3] = 24'd60;
        exp_rdy[0] = 1'b1; exp_rdy[1] = 1'b1; exp_rdy[2] = 1'b1;
        exp_rdy[3] = 1'b0; exp_rdy[4] = 1'b0;
        res_q.delete();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_mode   = 2'd0;
        in_a = va[0]; in_b = va[0]; in_c = va[0];
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== exp_rdy[i]) begin
                failures++;
                $display("FAIL bp_in_ready[%0d]: got %0b want %0b", i, in_ready, exp_rdy[i]);
            end
            if (i >= 3) begin
                cs = out_sum + out_carry;
                checks++;
                if (out_valid !== 1'b1 || out_total !== 24'd3 || cs !== 24'd3) begin
                    failures++;
                    $display("FAIL bp_hold[%0d]: got valid=%0b total=%0d cs=%0d want 1/3/3",
                             i, out_valid, out_total, cs);
                end
            end
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                idx++;
                if (idx < 4) begin
                    in_a = va[idx]; in_b = va[idx]; in_c = va[idx];
                end
            end
        end
        checks++;
        if (idx !== 3) begin
            failures++;
            $display("FAIL bp_accept_count: got %0d want 3", idx);
        end
        out_ready = 1'b1;
        while (idx < 4 && n < 20) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) idx++;
            n++;
        end
        in_valid = 1'b0;
        wait_results(4);
        if (res_q.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                cs = res_q[i].sum + res_q[i].carry;
                checks++;
                if (res_q[i].total !== exp_t[i] || cs !== exp_t[i]) begin
                    failures++;
                    $display("FAIL bp_order[%0d]: got total=%0d cs=%0d want %0d",
                             i, res_q[i].total, cs, exp_t[i]);
                end
            end
        end
        idle(4);
        checks++;
        if (res_q.size() !== 4) begin
            failures++;
            $display("FAIL bp_result_count: got %0d want 4", res_q.size());
        end
    endtask

    task automatic test_reset_midflight();
        int ac;
        res_q.delete();
        send(2'd2, 20'd7, 20'd0, 20'd0, ac);
        idle(1);
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL midrst_flags: got valid=%0b ready=%0b want 0/1", out_valid, in_ready);
        end
        checks++;
        if (dut.acc_s !== 24'h0 || dut.acc_c !== 24'h0) begin
            failures++;
            $display("FAIL midrst_acc: got acc_s=%h acc_c=%h want 0", dut.acc_s, dut.acc_c);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL midrst_valid[%0d]: got %0b want 0", i, out_valid);
            end
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(2'd1, 20'd1, 20'd1, 20'd1, ac);
        idle(1);
        wait_results(1);
        idle(5);
        checks++;
        if (res_q.size() !== 1) begin
            failures++;
            $display("FAIL midrst_count: got %0d results want 1", res_q.size());
        end
        if (res_q.size() >= 1) begin
            checks++;
            if (res_q[0].total !== 24'd3) begin
                failures++;
                $display("FAIL midrst_total: got %0d want 3", res_q[0].total);
            end
        end
    endtask

    task automatic test_mode3();
        int ac;
        res_q.delete();
        send(2'd2, 20'd1, 20'd0, 20'd0, ac);
        send(2'd3, 20'd5, 20'd5, 20'd5, ac);
        send(2'd1, 20'd0, 20'd0, 20'd0, ac);
        idle(1);
        wait_results(3);
        if (res_q.size() >= 3) begin
            checks++;
            if (res_q[0].total !== 24'd1) begin
                failures++;
                $display("FAIL mode3_load: got %0d want 1", res_q[0].total);
            end
            checks++;
            if (res_q[1].total !== 24'd15) begin
                failures++;
                $display("FAIL mode3_rsvd: got %0d want 15", res_q[1].total);
            end
            checks++;
            if (res_q[2].total !== 24'd1) begin
                failures++;
                $display("FAIL mode3_acc_untouched: got %0d want 1", res_q[2].total);
            end
        end
        idle(3);
    endtask

    initial begin
        test_reset();
        test_sum_max();
        test_back_to_back();
        test_wrap();
        test_backpressure();
        test_reset_midflight();
        test_mode3();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
